// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared constants for the SPI configuration-register block.
//   - register address map (7-bit addresses)
//   - frame length and field bit positions within the 16-bit frame
//   - bit-counter width (holds 0..FRAME_BITS+1)
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;
    localparam int CNT_W      = 5;
    localparam int NUM_REGS   = 5;

    // Frame layout, MSB first on the wire: R/W, 7-bit address, 8-bit data
    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'd0;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'd1;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'd2;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'd3;
    localparam logic [6:0] ADDR_PWM_DUTY  = 7'd4;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser for one asynchronous pin, followed by
// a history flop for edge detection.
//   clk, rst_n : system clock, asynchronous active-low reset
//   pin        : asynchronous input
//   level      : synchronised level
//   rise, fall : one-clk pulses on synchronised rising / falling edges
// RESET_VAL sets the value of every flop during reset so that an idle-high pin
// (chip select) does not produce a spurious edge on reset release.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: write-only SPI (mode 0) slave that loads five 8-bit
// configuration registers.
//   clk, rst_n        : system clock, asynchronous active-low reset
//   sclk, copi, ncs   : SPI pins, asynchronous to clk
//   en_reg_out_7_0    : reg 0x00, en_reg_out_15_8 : reg 0x01
//   en_reg_pwm_7_0    : reg 0x02, en_reg_pwm_15_8 : reg 0x03
//   pwm_duty_cycle    : reg 0x04
//   frame_err         : one-clk pulse when a frame ends with 1..15 or >16 bits
//   busy              : high while the synchronised chip select is low
// A frame is 16 bits MSB first: R/W (1 = write), 7-bit address, 8-bit data.
// It is decoded on the synchronised ncs rise; reads and out-of-range writes
// are dropped without error.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = spi_reg_pkg::FRAME_BITS,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       frame_err,
    output logic       busy
);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, copi_rise, copi_fall;
    logic ncs_lvl,  ncs_rise,  ncs_fall;
    logic unused_edges;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .pin(sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .pin(copi),
        .level(copi_lvl), .rise(copi_rise), .fall(copi_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .pin(ncs),
        .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
    );

    // Edge outputs this block has no use for (mode 0 samples on sclk rise only).
    assign unused_edges = sclk_lvl | sclk_fall | copi_rise | copi_fall;

    logic [FRAME_BITS-1:0] shift_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [6:0]            frame_addr;
    logic [7:0]            frame_data;
    logic                  frame_wr;

    assign frame_wr   = shift_q[RW_BIT];
    assign frame_addr = shift_q[ADDR_MSB:ADDR_LSB];
    assign frame_data = shift_q[7:0];

    // Priority: ncs fall (frame start) > ncs rise (frame end) > sclk rise.
    // A sclk rise coinciding with either ncs edge is therefore dropped, and the
    // end-of-frame decode sees the count from before that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q         <= '0;
            cnt_q           <= '0;
            busy            <= 1'b0;
            frame_err       <= 1'b0;
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
        end else begin
            frame_err <= 1'b0;
            if (ncs_fall) begin
                shift_q <= '0;
                cnt_q   <= '0;
                busy    <= 1'b1;
            end else if (ncs_rise) begin
                busy <= 1'b0;
                if (cnt_q == CNT_W'(FRAME_BITS)) begin
                    if (frame_wr && (frame_addr <= 7'(MAX_ADDR))) begin
                        case (frame_addr)
                            ADDR_EN_OUT_LO: en_reg_out_7_0  <= frame_data;
                            ADDR_EN_OUT_HI: en_reg_out_15_8 <= frame_data;
                            ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= frame_data;
                            ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= frame_data;
                            ADDR_PWM_DUTY:  pwm_duty_cycle  <= frame_data;
                            default: ;
                        endcase
                    end
                end else if (cnt_q != '0) begin
                    // Short or overrun frame; an empty ncs pulse is not an error.
                    frame_err <= 1'b1;
                end
            end else if (sclk_rise && !ncs_lvl) begin
                if (cnt_q < CNT_W'(FRAME_BITS)) begin
                    shift_q <= {shift_q[FRAME_BITS-2:0], copi_lvl};
                end
                // Saturate at FRAME_BITS+1 so any overrun stays distinguishable.
                if (cnt_q < CNT_W'(FRAME_BITS + 1)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: drives SPI frames at sclk = clk/8 and compares the register
// outputs, busy and the frame_err pulse count against a register-map model.
module tb_spi_reg_ctrl;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       frame_err;
    logic       busy;

    spi_reg_ctrl dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .frame_err(frame_err), .busy(busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int         total = 0;
    int         bad   = 0;
    logic [7:0] mdl_regs [5];
    int         exp_err  = 0;
    int         err_seen = 0;
    int         err_wide = 0;
    logic       err_prev = 1'b0;

    always @(negedge clk) begin
        if (frame_err) begin
            err_seen++;
            if (err_prev) err_wide++;
        end
        err_prev = frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic compare_all(input string tag);
        check({tag, " reg0"}, {24'd0, en_reg_out_7_0},  {24'd0, mdl_regs[0]});
        check({tag, " reg1"}, {24'd0, en_reg_out_15_8}, {24'd0, mdl_regs[1]});
        check({tag, " reg2"}, {24'd0, en_reg_pwm_7_0},  {24'd0, mdl_regs[2]});
        check({tag, " reg3"}, {24'd0, en_reg_pwm_15_8}, {24'd0, mdl_regs[3]});
        check({tag, " reg4"}, {24'd0, pwm_duty_cycle},  {24'd0, mdl_regs[4]});
        check({tag, " err_count"}, err_seen, exp_err);
        check({tag, " busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic frame_begin();
        ncs = 1'b0;
        wait_clk(4);
        check("busy_in_frame", {31'd0, busy}, 32'd1);
    endtask

    task automatic send_bit(input logic b);
        copi = b;
        wait_clk(4);
        sclk = 1'b1;
        wait_clk(4);
        sclk = 1'b0;
    endtask

    task automatic frame_end();
        wait_clk(4);
        ncs = 1'b1;
    endtask

    // Sends n bits: the first up to 16 come from word MSB first, the rest are
    // random filler. The model applies the register-map rules to the outcome.
    task automatic apply_frame(input string tag, input logic [15:0] word, input int n);
        logic [6:0] addr;
        addr = word[14:8];
        frame_begin();
        for (int i = 0; i < n; i++) begin
            if (i < 16) send_bit(word[15-i]);
            else        send_bit(1'($urandom_range(0, 1)));
        end
        frame_end();
        if (n == 16) begin
            if (word[15] && addr <= 7'd4) mdl_regs[addr] = word[7:0];
        end else if (n != 0) begin
            exp_err++;
        end
        wait_clk(4);
        compare_all(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] w;
        int          n;
        int          r;

        rst_n = 1'b0;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs   = 1'b1;
        for (int i = 0; i < 5; i++) mdl_regs[i] = 8'h00;
        wait_clk(3);
        compare_all("reset");
        check("reset frame_err", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        wait_clk(4);
        compare_all("post_reset");

        apply_frame("wr_addr0", 16'h80F0, 16);
        apply_frame("wr_addr4", 16'h8480, 16);
        apply_frame("read_addr4", 16'h04AA, 16);
        apply_frame("wr_addr5", 16'h8555, 16);
        apply_frame("wr_addr7f", 16'hFF11, 16);
        apply_frame("short15", 16'h8233, 15);
        apply_frame("long20", 16'h8233, 20);
        apply_frame("wr_addr2", 16'h8233, 16);
        apply_frame("glitch", 16'h0000, 0);

        // Reset in the middle of a frame.
        apply_frame("wr_addr1", 16'h810F, 16);
        frame_begin();
        for (int i = 0; i < 9; i++) send_bit(((16'h81FF >> (15 - i)) & 16'h1) != 16'h0);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) mdl_regs[i] = 8'h00;
        compare_all("mid_reset");
        check("mid_reset frame_err", {31'd0, frame_err}, 32'd0);
        ncs  = 1'b1;
        sclk = 1'b0;
        copi = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
        compare_all("after_reset_release");
        apply_frame("wr_addr1_again", 16'h81FF, 16);

        // Randomised frames: lengths 0..20, mostly writes to nearby addresses.
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      n = 0;
            else if (r <= 2) n = $urandom_range(1, 15);
            else if (r <= 7) n = 16;
            else             n = $urandom_range(17, 20);
            w[15]   = ($urandom_range(0, 3) != 0);
            w[14:8] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                                  : 7'($urandom_range(0, 5));
            w[7:0]  = 8'($urandom_range(0, 255));
            apply_frame("random", w, n);
        end

        check("frame_err_width", err_wide, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
